// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetris display path: cell codes, palette, screen size.
package tetris_pkg;

    typedef enum logic [2:0] {EMPTY, I, O, T, S, Z, J, L} cell_code_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] GRID_COLOUR = 3'b000;

    localparam logic [2:0] PALETTE [0:15] = '{
        3'b000, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100, 3'b001, 3'b111,
        3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111, 3'b010
    };

    // Counter width for a range of n values; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cell_pixel_walker.sv
// Raster walk over the pixels of one cell: px runs fastest, both counters wrap after the last pixel.
module cell_pixel_walker
    import tetris_pkg::*;
#(
    parameter int CELL_W = 6,
    parameter int CELL_H = 6
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    input  logic                        go,
    output logic [cnt_w(CELL_W)-1:0]    px,
    output logic [cnt_w(CELL_H)-1:0]    py,
    output logic                        last_px,
    output logic                        is_edge
);

    localparam int PX_W = cnt_w(CELL_W);
    localparam int PY_W = cnt_w(CELL_H);
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(CELL_W - 1);
    localparam logic [PY_W-1:0] PY_LAST = PY_W'(CELL_H - 1);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            px <= '0;
            py <= '0;
        end else if (go) begin
            if (px == PX_LAST) begin
                px <= '0;
                py <= (py == PY_LAST) ? '0 : py + PY_W'(1);
            end else begin
                px <= px + PX_W'(1);
            end
        end
    end

    assign last_px = (px == PX_LAST) && (py == PY_LAST);
    assign is_edge = (px == PX_LAST) || (py == PY_LAST);

endmodule

// File: rtl/board_renderer.sv
// Snapshots the board on request and redraws changed cells through the palette
// onto the vga_adapter write port.
module board_renderer
    import tetris_pkg::*;
#(
    parameter int COLS     = 10,
    parameter int ROWS     = 20,
    parameter int CELL_W   = 6,
    parameter int CELL_H   = 6,
    parameter int CODE_W   = 3,
    parameter int COLOUR_W = 3,
    parameter int X_OFF    = 0,
    parameter int Y_OFF    = 0,
    parameter int GRID_EN  = 1
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic [ROWS*COLS*CODE_W-1:0]   board,
    input  logic                          start,
    input  logic                          force_full,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    x,
    output logic [6:0]                    y,
    output logic [COLOUR_W-1:0]           colour,
    output logic                          plot
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = cnt_w(N);
    localparam int COL_W = cnt_w(COLS);
    localparam int PX_W  = cnt_w(CELL_W);
    localparam int PY_W  = cnt_w(CELL_H);

    generate
        if (X_OFF + COLS * CELL_W > SCREEN_W) begin : g_bad_width
            $error("board_renderer: board does not fit the screen horizontally");
        end
        if (Y_OFF + ROWS * CELL_H > SCREEN_H) begin : g_bad_height
            $error("board_renderer: board does not fit the screen vertically");
        end
        if (CODE_W > 4) begin : g_bad_code
            $error("board_renderer: CODE_W exceeds palette index width");
        end
    endgenerate

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SNAP = 3'd1;
    localparam logic [2:0] S_SCAN = 3'd2;
    localparam logic [2:0] S_DRAW = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          state;
    logic                full_now;
    logic                full_pend;
    logic [N*CODE_W-1:0] snap;
    logic [N*CODE_W-1:0] prev;
    logic [IDX_W-1:0]    idx;
    logic [COL_W-1:0]    col;
    logic [7:0]          cell_x;
    logic [6:0]          cell_y;

    logic [PX_W-1:0]     px;
    logic [PY_W-1:0]     py;
    logic                last_px;
    logic                is_edge;

    logic [CODE_W-1:0]   snap_code;
    logic [CODE_W-1:0]   prev_code;
    logic                dirty;
    logic                last_cell;
    logic                advance;
    logic [COLOUR_W-1:0] pix_colour;

    cell_pixel_walker #(
        .CELL_W (CELL_W),
        .CELL_H (CELL_H)
    ) u_walker (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .go       (state == S_DRAW),
        .px       (px),
        .py       (py),
        .last_px  (last_px),
        .is_edge  (is_edge)
    );

    assign snap_code = snap[idx*CODE_W +: CODE_W];
    assign prev_code = prev[idx*CODE_W +: CODE_W];
    assign dirty     = full_now || (snap_code != prev_code);
    assign last_cell = (idx == IDX_W'(N - 1));
    assign advance   = !last_cell &&
                       (((state == S_SCAN) && !dirty) || ((state == S_DRAW) && last_px));
    assign busy      = (state != S_IDLE);

    always_comb begin
        pix_colour = COLOUR_W'(PALETTE[4'(snap_code)]);
        if ((GRID_EN != 0) && is_edge)
            pix_colour = COLOUR_W'(GRID_COLOUR);
    end

    // Cell position is tracked incrementally in pixel units so no divide or modulo is needed.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            idx    <= '0;
            col    <= '0;
            cell_x <= '0;
            cell_y <= '0;
        end else if (state == S_SNAP) begin
            idx    <= '0;
            col    <= '0;
            cell_x <= 8'(X_OFF);
            cell_y <= 7'(Y_OFF);
        end else if (advance) begin
            idx <= idx + IDX_W'(1);
            if (col == COL_W'(COLS - 1)) begin
                col    <= '0;
                cell_x <= 8'(X_OFF);
                cell_y <= cell_y + 7'(CELL_H);
            end else begin
                col    <= col + COL_W'(1);
                cell_x <= cell_x + 8'(CELL_W);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            full_now  <= 1'b0;
            full_pend <= 1'b1;
            snap      <= '0;
            prev      <= '0;
            done      <= 1'b0;
            plot      <= 1'b0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
        end else begin
            done <= 1'b0;
            plot <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        full_now <= force_full | full_pend;
                        state    <= S_SNAP;
                    end
                end
                S_SNAP: begin
                    snap  <= board;
                    state <= S_SCAN;
                end
                S_SCAN: begin
                    if (dirty)
                        state <= S_DRAW;
                    else if (last_cell)
                        state <= S_DONE;
                end
                S_DRAW: begin
                    plot   <= 1'b1;
                    x      <= cell_x + 8'(px);
                    y      <= cell_y + 7'(py);
                    colour <= pix_colour;
                    if (last_px) begin
                        prev[idx*CODE_W +: CODE_W] <= snap_code;
                        state <= last_cell ? S_DONE : S_SCAN;
                    end
                end
                S_DONE: begin
                    done      <= 1'b1;
                    full_pend <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
